fu_matrix_ls_seq: RTL and testbench

FU_MATRIX_LS_SEQ -- requirements
Module: fu_matrix_ls_seq

---
 rtl/fu_matrix_ls_seq.sv | 143 ++++++++++++++
 tb/tb_fu_matrix_ls_seq.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fu_matrix_ls_seq.sv
// Matrix load/store row sequencer: walks base + i*stride, issues row requests to the
// scratchpad with a bounded in-flight count and pulses done once every row has completed.
module fu_matrix_ls_seq #(
    parameter  int unsigned WORD_W   = 32,
    parameter  int unsigned MAX_ROWS = 4,
    parameter  int unsigned MAX_OUT  = 2,
    parameter  int unsigned MAT_W    = 2,
    localparam int unsigned ROW_W    = $clog2(MAX_ROWS + 1),
    localparam int unsigned OUT_W    = $clog2(MAX_OUT + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              freeze,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_ls,
    input  logic [MAT_W-1:0]  req_mat,
    input  logic [WORD_W-1:0] req_base,
    input  logic [WORD_W-1:0] req_stride,
    input  logic [ROW_W-1:0]  req_rows,
    output logic              sp_valid,
    input  logic              sp_ready,
    output logic              sp_ls,
    output logic [WORD_W-1:0] sp_addr,
    output logic [ROW_W-1:0]  sp_row,
    output logic [MAT_W-1:0]  sp_mat,
    input  logic              mhit,
    output logic              done,
    output logic [MAT_W-1:0]  done_mat,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StDone, StDrain} state_e;

    state_e            state;
    logic [ROW_W-1:0]  issued;
    logic [ROW_W-1:0]  completed;
    logic [ROW_W-1:0]  rows;
    logic [OUT_W-1:0]  outstanding;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] stride;
    logic              ls;
    logic [MAT_W-1:0]  mat;

    logic              accept;
    logic              issue_fire;
    logic              hit;
    logic [OUT_W-1:0]  out_next;
    logic [ROW_W-1:0]  completed_next;
    logic [ROW_W-1:0]  rows_clamped;

    always_comb begin
        req_ready  = (state == StIdle) && !freeze && !flush;
        accept     = req_valid && req_ready;
        sp_valid   = (state == StIssue) && (issued < rows) &&
                     (outstanding < OUT_W'(MAX_OUT)) && !freeze && !flush;
        issue_fire = sp_valid && sp_ready;
        // A completion with nothing in flight is stray and must not underflow the count.
        hit        = mhit && (outstanding != '0);

        out_next = outstanding;
        if (issue_fire && !hit) begin
            out_next = outstanding + OUT_W'(1);
        end else if (hit && !issue_fire) begin
            out_next = outstanding - OUT_W'(1);
        end

        completed_next = completed + ROW_W'(hit);
        rows_clamped   = (req_rows > ROW_W'(MAX_ROWS)) ? ROW_W'(MAX_ROWS) : req_rows;

        sp_addr  = addr;
        sp_row   = issued;
        sp_ls    = ls;
        sp_mat   = mat;
        done     = (state == StDone) && !freeze && !flush;
        done_mat = mat;
        busy     = (state != StIdle);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= StIdle;
            issued      <= '0;
            completed   <= '0;
            rows        <= '0;
            outstanding <= '0;
            addr        <= '0;
            stride      <= '0;
            ls          <= 1'b0;
            mat         <= '0;
        end else begin
            // Completions are counted in every state, even while frozen.
            outstanding <= out_next;
            case (state)
                StIdle: begin
                    if (accept) begin
                        ls        <= req_ls;
                        mat       <= req_mat;
                        stride    <= req_stride;
                        addr      <= req_base;
                        rows      <= rows_clamped;
                        issued    <= '0;
                        completed <= '0;
                        state     <= StIssue;
                    end
                end
                StIssue: begin
                    if (flush) begin
                        issued    <= '0;
                        completed <= '0;
                        state     <= (out_next != '0) ? StDrain : StIdle;
                    end else begin
                        completed <= completed_next;
                        if (issue_fire) begin
                            addr   <= addr + stride;
                            issued <= issued + ROW_W'(1);
                        end
                        if (!freeze && (completed_next == rows)) begin
                            state <= StDone;
                        end
                    end
                end
                StDone: begin
                    if (flush) begin
                        issued    <= '0;
                        completed <= '0;
                        state     <= (out_next != '0) ? StDrain : StIdle;
                    end else if (!freeze) begin
                        state <= StIdle;
                    end
                end
                StDrain: begin
                    if (!freeze && (out_next == '0)) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fu_matrix_ls_seq.sv
// Directed bench for fu_matrix_ls_seq: scripted requests, a falling-edge scoreboard of
// accepted row requests and done pulses, and an optional fixed two-cycle mhit responder.
`timescale 1ns/1ps
module tb_fu_matrix_ls_seq;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned MAT_W  = 2;
    localparam int unsigned ROW_W  = 3;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              flush = 1'b0;
    logic              freeze = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ls = 1'b0;
    logic [MAT_W-1:0]  req_mat = '0;
    logic [WORD_W-1:0] req_base = '0;
    logic [WORD_W-1:0] req_stride = '0;
    logic [ROW_W-1:0]  req_rows = '0;
    logic              sp_ready = 1'b1;
    logic              req_ready, sp_valid, sp_ls, done, busy, mhit;
    logic [WORD_W-1:0] sp_addr;
    logic [ROW_W-1:0]  sp_row;
    logic [MAT_W-1:0]  sp_mat, done_mat;

    logic              auto_hit = 1'b0;
    logic              man_mhit = 1'b0;
    logic              acc_s = 1'b0;
    logic [1:0]        pipe = 2'b00;

    int tests = 0;
    int fails = 0;
    int cyc = 0, done_cnt = 0, done_cyc = 0, hit_cyc = 0, req_cyc = 0, sv_cnt = 0;
    int out_m = 0, max_out = 0;
    logic [MAT_W-1:0]  done_mat_s = '0;
    logic [WORD_W-1:0] addr_q[$];
    logic [ROW_W-1:0]  row_q[$];
    logic              ls_q[$];

    fu_matrix_ls_seq dut (
        .CLK(CLK), .RST(RST), .flush(flush), .freeze(freeze),
        .req_valid(req_valid), .req_ready(req_ready), .req_ls(req_ls), .req_mat(req_mat),
        .req_base(req_base), .req_stride(req_stride), .req_rows(req_rows),
        .sp_valid(sp_valid), .sp_ready(sp_ready), .sp_ls(sp_ls), .sp_addr(sp_addr),
        .sp_row(sp_row), .sp_mat(sp_mat), .mhit(mhit),
        .done(done), .done_mat(done_mat), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // Responder: mhit is sampled by the DUT two edges after the accepting edge.
    assign mhit = auto_hit ? pipe[1] : man_mhit;
    always @(posedge CLK) pipe <= {pipe[0], acc_s};

    always @(negedge CLK) begin
        int n;
        cyc   <= cyc + 1;
        acc_s <= !RST && sp_valid && sp_ready;
        if (RST) begin
            out_m <= 0;
        end else begin
            if (sp_valid && sp_ready) begin
                addr_q.push_back(sp_addr);
                row_q.push_back(sp_row);
                ls_q.push_back(sp_ls);
            end
            if (sp_valid) sv_cnt <= sv_cnt + 1;
            if (done) begin
                done_cnt   <= done_cnt + 1;
                done_cyc   <= cyc;
                done_mat_s <= done_mat;
            end
            if (mhit) hit_cyc <= cyc;
            if (req_valid && req_ready) req_cyc <= cyc;
            n = out_m + ((sp_valid && sp_ready) ? 1 : 0) - ((mhit && out_m > 0) ? 1 : 0);
            out_m <= n;
            if (n > max_out) max_out <= n;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic ls, input logic [MAT_W-1:0] mat,
                        input logic [WORD_W-1:0] base, input logic [WORD_W-1:0] stride,
                        input logic [ROW_W-1:0] rows);
        req_ls = ls; req_mat = mat; req_base = base; req_stride = stride; req_rows = rows;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic pulse_hit();
        man_mhit = 1'b1;
        tick();
        man_mhit = 1'b0;
        #1;
    endtask

    task automatic wait_done(input int d0, input int maxc, input string name);
        int n = 0;
        while (done_cnt == d0 && n < maxc) begin
            tick();
            n++;
        end
        tests++;
        if (done_cnt == d0) begin
            fails++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, maxc);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick(); tick();
        RST = 1'b0;
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL rst_done: got %b want 0", done); end
        tests++; if (sp_valid !== 1'b0) begin fails++; $display("FAIL rst_spv: got %b want 0", sp_valid); end
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_rdy: got %b want 1", req_ready); end
    endtask

    task automatic test_load();
        logic [WORD_W-1:0] exp[4];
        int a0 = addr_q.size();
        int d0 = done_cnt;
        exp[0] = 32'h1000; exp[1] = 32'h1040; exp[2] = 32'h1080; exp[3] = 32'h10C0;
        auto_hit = 1'b1; sp_ready = 1'b1;
        send(1'b0, 2'd2, 32'h1000, 32'h40, 3'd4);
        wait_done(d0, 60, "load");
        tick(); tick();
        tests++;
        if (addr_q.size() - a0 != 4) begin
            fails++; $display("FAIL load_count: got %0d want 4", addr_q.size() - a0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (addr_q[a0+i] !== exp[i]) begin
                    fails++; $display("FAIL load_addr%0d: got %h want %h", i, addr_q[a0+i], exp[i]);
                end
            end
        end
        tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL load_done_cnt: got %0d want 1", done_cnt - d0); end
        tests++; if (done_mat_s !== 2'd2) begin fails++; $display("FAIL load_done_mat: got %0d want 2", done_mat_s); end
        tests++; if (done_cyc != hit_cyc + 1) begin fails++; $display("FAIL load_done_lat: got %0d want %0d", done_cyc - hit_cyc, 1); end
        tests++; if (max_out > 2) begin fails++; $display("FAIL load_max_out: got %0d want <=2", max_out); end
        auto_hit = 1'b0;
    endtask

    task automatic test_wrap();
        logic [WORD_W-1:0] exp[3];
        int a0 = addr_q.size();
        int d0 = done_cnt;
        int bad = 0;
        exp[0] = 32'hFFFF_FFF0; exp[1] = 32'h0000_0000; exp[2] = 32'h0000_0010;
        auto_hit = 1'b1; sp_ready = 1'b0;
        send(1'b1, 2'd1, 32'hFFFF_FFF0, 32'h10, 3'd3);
        for (int i = 0; i < 2; i++) begin
            if (sp_valid !== 1'b1 || sp_addr !== 32'hFFFF_FFF0) bad++;
            tick();
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL wrap_hold: got %0d unstable cycles want 0", bad); end
        sp_ready = 1'b1;
        wait_done(d0, 60, "wrap");
        tests++;
        if (addr_q.size() - a0 != 3) begin
            fails++; $display("FAIL wrap_count: got %0d want 3", addr_q.size() - a0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (addr_q[a0+i] !== exp[i]) begin
                    fails++; $display("FAIL wrap_addr%0d: got %h want %h", i, addr_q[a0+i], exp[i]);
                end
            end
            tests++; if (ls_q[a0] !== 1'b1) begin fails++; $display("FAIL wrap_ls: got %b want 1", ls_q[a0]); end
        end
        auto_hit = 1'b0;
    endtask

    task automatic test_zero_rows();
        int a0 = addr_q.size();
        int d0 = done_cnt;
        int s0 = sv_cnt;
        auto_hit = 1'b1;
        send(1'b0, 2'd3, 32'h8000, 32'h4, 3'd0);
        wait_done(d0, 20, "zero");
        tick();
        tests++; if (sv_cnt != s0) begin fails++; $display("FAIL zero_spv: got %0d cycles want 0", sv_cnt - s0); end
        tests++; if (addr_q.size() != a0) begin fails++; $display("FAIL zero_reqs: got %0d want 0", addr_q.size() - a0); end
        tests++; if (done_cyc - req_cyc != 2) begin fails++; $display("FAIL zero_lat: got %0d want 2", done_cyc - req_cyc); end
        auto_hit = 1'b0;
    endtask

    task automatic test_clamp();
        int a0 = addr_q.size();
        int d0 = done_cnt;
        auto_hit = 1'b1;
        send(1'b0, 2'd0, 32'h100, 32'h4, 3'd7);
        wait_done(d0, 60, "clamp");
        tick(); tick();
        tests++;
        if (addr_q.size() - a0 != 4) begin
            fails++; $display("FAIL clamp_count: got %0d want 4", addr_q.size() - a0);
        end else begin
            tests++; if (row_q[a0+3] !== 3'd3) begin fails++; $display("FAIL clamp_row: got %0d want 3", row_q[a0+3]); end
            tests++; if (addr_q[a0+3] !== 32'h10C) begin fails++; $display("FAIL clamp_addr: got %h want 0000010c", addr_q[a0+3]); end
        end
        auto_hit = 1'b0;
    endtask

    task automatic test_freeze();
        logic [WORD_W-1:0] exp[4];
        int a0 = addr_q.size();
        int d0 = done_cnt;
        int bad = 0;
        exp[0] = 32'h2000; exp[1] = 32'h2008; exp[2] = 32'h2010; exp[3] = 32'h2018;
        auto_hit = 1'b0; sp_ready = 1'b1;
        send(1'b0, 2'd1, 32'h2000, 32'h8, 3'd4);
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            freeze = 1'b1;
            man_mhit = (i == 1 || i == 3);
            #1;
            if (sp_valid !== 1'b0 || req_ready !== 1'b0 || done !== 1'b0) bad++;
            tick();
        end
        freeze = 1'b0; man_mhit = 1'b0;
        #1;
        tests++; if (bad != 0) begin fails++; $display("FAIL frz_outputs: got %0d active cycles want 0", bad); end
        tests++; if (sp_valid !== 1'b1 || sp_addr !== 32'h2010) begin
            fails++; $display("FAIL frz_resume: got valid=%b addr=%h want 1 00002010", sp_valid, sp_addr);
        end
        tick(); tick();
        pulse_hit();
        pulse_hit();
        freeze = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (done !== 1'b0 || busy !== 1'b1) bad++;
            tick();
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL frz_done_hold: got %0d bad cycles want 0", bad); end
        freeze = 1'b0;
        #1;
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL frz_done_release: got %b want 1", done); end
        tick(); tick();
        tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL frz_done_cnt: got %0d want 1", done_cnt - d0); end
        tests++;
        if (addr_q.size() - a0 != 4) begin
            fails++; $display("FAIL frz_count: got %0d want 4", addr_q.size() - a0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (addr_q[a0+i] !== exp[i]) begin
                    fails++; $display("FAIL frz_addr%0d: got %h want %h", i, addr_q[a0+i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_flush();
        int a0;
        int d0 = done_cnt;
        int bad = 0;
        auto_hit = 1'b0;
        send(1'b1, 2'd3, 32'h3000, 32'h100, 3'd4);
        tick(); tick();
        flush = 1'b1; req_valid = 1'b1;
        #1;
        tests++; if (req_ready !== 1'b0 || sp_valid !== 1'b0) begin
            fails++; $display("FAIL fl_gate: got rdy=%b spv=%b want 0 0", req_ready, sp_valid);
        end
        tick();
        flush = 1'b0; req_valid = 1'b0;
        a0 = addr_q.size();
        for (int i = 0; i < 3; i++) begin
            flush = (i == 1);
            #1;
            if (busy !== 1'b1 || req_ready !== 1'b0 || sp_valid !== 1'b0) bad++;
            tick();
        end
        flush = 1'b0;
        tests++; if (bad != 0) begin fails++; $display("FAIL fl_drain: got %0d bad cycles want 0", bad); end
        pulse_hit();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL fl_one_hit: got busy=%b want 1", busy); end
        pulse_hit();
        tests++; if (busy !== 1'b0 || req_ready !== 1'b1) begin
            fails++; $display("FAIL fl_idle: got busy=%b rdy=%b want 0 1", busy, req_ready);
        end
        tests++; if (done_cnt != d0 || addr_q.size() != a0) begin
            fails++; $display("FAIL fl_no_done: got done=%0d reqs=%0d want 0 0", done_cnt - d0, addr_q.size() - a0);
        end
        auto_hit = 1'b1;
        send(1'b0, 2'd1, 32'h4000, 32'h4, 3'd2);
        wait_done(d0, 40, "fl_next");
        tests++; if (addr_q.size() - a0 != 2 || addr_q[a0+1] !== 32'h4004) begin
            fails++; $display("FAIL fl_next_addr: got n=%0d want 2 ending 00004004", addr_q.size() - a0);
        end
        tests++; if (done_mat_s !== 2'd1) begin fails++; $display("FAIL fl_next_mat: got %0d want 1", done_mat_s); end
        auto_hit = 1'b0;
    endtask

    task automatic test_reset_inflight();
        int a0;
        int d0;
        auto_hit = 1'b0;
        send(1'b1, 2'd2, 32'h5000, 32'h10, 3'd4);
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        tests++; if (busy !== 1'b0 || sp_valid !== 1'b0 || done !== 1'b0) begin
            fails++; $display("FAIL rsti_outs: got busy=%b spv=%b done=%b want 0 0 0", busy, sp_valid, done);
        end
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rsti_rdy: got %b want 1", req_ready); end
        tests++; if (sp_addr !== 32'h0 || sp_row !== 3'd0 || sp_mat !== 2'd0 || sp_ls !== 1'b0) begin
            fails++; $display("FAIL rsti_regs: got addr=%h row=%0d mat=%0d ls=%b want 0", sp_addr, sp_row, sp_mat, sp_ls);
        end
        pulse_hit();
        tests++; if (busy !== 1'b0 || req_ready !== 1'b1) begin
            fails++; $display("FAIL rsti_stray: got busy=%b rdy=%b want 0 1", busy, req_ready);
        end
        a0 = addr_q.size();
        d0 = done_cnt;
        auto_hit = 1'b1;
        send(1'b0, 2'd3, 32'h6000, 32'h20, 3'd2);
        wait_done(d0, 40, "rsti_next");
        tests++; if (addr_q.size() - a0 != 2 || addr_q[a0] !== 32'h6000) begin
            fails++; $display("FAIL rsti_next: got n=%0d want 2 from 00006000", addr_q.size() - a0);
        end
        auto_hit = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_wrap();
        test_zero_rows();
        test_clamp();
        test_freeze();
        test_flush();
        test_reset_inflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
